// File: rtl/mem_arbiter_if.sv
// Bundle of pipeline-side and memory-side signals around mem_arbiter.
// Signal names keep the arbiter's point of view: *_i are driven into the
// arbiter and *_o are driven by it.
//   slave  : arbiter side (mem_arbiter port)
//   master : environment side (IF/MEM stages plus backing memory)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_done_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_done_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  logic              stall_o;
  logic              timeout_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_rdata_i, mem_ack_i,
    output if_data_o, if_done_o,
    output d_rdata_o, d_done_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output stall_o, timeout_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_rdata_i, mem_ack_i,
    input  if_data_o, if_done_o,
    input  d_rdata_o, d_done_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  stall_o, timeout_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch (IF)
// and data (MEM) stages and produces the global pipeline stall.
// Data has priority over fetch; one transfer at a time, with at least one
// idle cycle between transfers.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : mem_arbiter_if.slave (stage requests, memory port, stall,
//             timeout)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer outstanding, mem_req_o low, may grant next cycle
// BUSY_D | data-stage transfer on the memory port, waiting for ack
// BUSY_I | fetch transfer on the memory port, waiting for ack
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_t;

  // Wait timer runs down from MAX_WAIT; terminal count flags the timeout.
  localparam logic [7:0] WAIT_INIT = 8'(MAX_WAIT);

  state_t            state_q;
  state_t            state_d;

  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;
  logic              timeout_q;
  logic [7:0]        wait_cnt_q;

  logic              pend_d;
  logic              pend_i;
  logic              stall;
  logic              ack;
  logic              grant_d;
  logic              grant_i;
  logic              fin_d;
  logic              fin_i;

  assign pend_d = bus.d_req_i & ~d_done_q;
  assign pend_i = bus.if_req_i & ~if_done_q;
  // Gated by reset so the freeze drops immediately with the async reset,
  // even while the stages keep their requests asserted.
  assign stall  = (pend_d | pend_i) & rst_n_i;
  // Ack only counts while a request is actually on the port.
  assign ack    = bus.mem_ack_i & mem_req_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    fin_d   = 1'b0;
    fin_i   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_d) begin
          state_d = BUSY_D;
          grant_d = 1'b1;
        end else if (pend_i) begin
          state_d = BUSY_I;
          grant_i = 1'b1;
        end
      end
      BUSY_D: begin
        if (ack) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end
      end
      BUSY_I: begin
        if (ack) begin
          state_d = IDLE;
          fin_i   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port registers, wait timer and sticky timeout.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (grant_d) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= bus.d_we_i;
        mem_addr_q  <= bus.d_addr_i;
        mem_wdata_q <= bus.d_wdata_i;
        wait_cnt_q  <= WAIT_INIT;
      end else if (grant_i) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.if_addr_i;
        wait_cnt_q  <= WAIT_INIT;
      end else if (fin_d || fin_i) begin
        mem_req_q   <= 1'b0;
        wait_cnt_q  <= '0;
      end else if (state_q != IDLE) begin
        // Saturate at zero; the transfer keeps waiting after a timeout.
        if (wait_cnt_q != 8'd0) begin
          wait_cnt_q <= wait_cnt_q - 8'd1;
        end
        if (wait_cnt_q == 8'd1) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  // Read data capture and done flags. A completion wins over the clear so a
  // transfer finishing while the pipeline advances (flushed request) still
  // leaves its done flag for one cycle before it is discarded.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if_data_q <= '0;
      d_rdata_q <= '0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      if (fin_d && !mem_we_q) begin
        d_rdata_q <= bus.mem_rdata_i;
      end
      if (fin_i) begin
        if_data_q <= bus.mem_rdata_i;
      end

      if (fin_d) begin
        d_done_q <= 1'b1;
      end else if (!stall) begin
        d_done_q <= 1'b0;
      end

      if (fin_i) begin
        if_done_q <= 1'b1;
      end else if (!stall) begin
        if_done_q <= 1'b0;
      end
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.d_done_o    = d_done_q;
  assign bus.stall_o     = stall;
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch only, load+fetch ordering, store,
// timeout and asynchronous reset mid-transfer. A small memory responder
// acks after a programmable delay and returns address-derived read data.
module tb_mem_arbiter;

  logic clk_i;
  logic rst_n_i;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_bad = 0;

  int          ack_delay = 0;
  logic        never_ack = 1'b0;
  logic [31:0] grants[$];

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] addr);
    if (addr == 32'h0000_0040) return 32'h8C22_0004;
    return addr ^ 32'h5A5A_0000;
  endfunction

  task automatic next_cyc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid;
    @(negedge clk_i);
  endtask

  // Memory responder: ack in the first busy cycle where the busy count has
  // reached ack_delay; also logs the address of every new transfer.
  initial begin
    int   cnt;
    logic prev_req;
    cnt             = 0;
    prev_req        = 1'b0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (bus.mem_req_o !== 1'b1) begin
        cnt           = 0;
        bus.mem_ack_i = 1'b0;
      end else begin
        if (!prev_req) grants.push_back(bus.mem_addr_o);
        if (!never_ack && cnt >= ack_delay && !bus.mem_ack_i) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = rd_val(bus.mem_addr_o);
        end else begin
          bus.mem_ack_i = 1'b0;
          if (cnt < 255) cnt++;
        end
      end
      prev_req = (bus.mem_req_o === 1'b1);
    end
  end

  initial begin
    rst_n_i       = 1'b0;
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = '0;
    bus.d_req_i   = 1'b0;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;

    // Reset state
    repeat (2) @(posedge clk_i);
    mid;
    check_val("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
    check_val("rst_stall",   64'(bus.stall_o),   64'd0);
    check_val("rst_if_data", 64'(bus.if_data_o), 64'd0);
    check_val("rst_timeout", 64'(bus.timeout_o), 64'd0);
    rst_n_i = 1'b1;

    // Fetch only, immediate ack
    next_cyc;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0040;
    ack_delay     = 0;
    mid;
    check_val("f_c0_stall",   64'(bus.stall_o),   64'd1);
    check_val("f_c0_mem_req", 64'(bus.mem_req_o), 64'd0);
    next_cyc; mid;
    check_val("f_c1_mem_req",  64'(bus.mem_req_o),  64'd1);
    check_val("f_c1_mem_addr", 64'(bus.mem_addr_o), 64'h40);
    check_val("f_c1_mem_we",   64'(bus.mem_we_o),   64'd0);
    next_cyc; mid;
    check_val("f_c2_if_done", 64'(bus.if_done_o), 64'd1);
    check_val("f_c2_if_data", 64'(bus.if_data_o), 64'h8C22_0004);
    check_val("f_c2_stall",   64'(bus.stall_o),   64'd0);
    check_val("f_c2_mem_req", 64'(bus.mem_req_o), 64'd0);
    next_cyc;
    bus.if_req_i = 1'b0;
    mid;
    check_val("f_c3_if_done", 64'(bus.if_done_o), 64'd0);

    // Load and fetch together, ack delay 3
    grants.delete();
    next_cyc;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = 32'h0000_0100;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0044;
    ack_delay     = 3;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) next_cyc;
      mid;
      check_val($sformatf("lf_c%0d_stall", c), 64'(bus.stall_o),
                64'(c < 10));
      check_val($sformatf("lf_c%0d_mem_req", c), 64'(bus.mem_req_o),
                64'((c >= 1 && c <= 4) || (c >= 6 && c <= 9)));
      if (c == 1) check_val("lf_c1_addr", 64'(bus.mem_addr_o), 64'h100);
      if (c == 6) check_val("lf_c6_addr", 64'(bus.mem_addr_o), 64'h44);
      if (c == 5) begin
        check_val("lf_c5_d_done",  64'(bus.d_done_o),  64'd1);
        check_val("lf_c5_d_rdata", 64'(bus.d_rdata_o), 64'h5A5A_0100);
      end
      if (c == 10) begin
        check_val("lf_c10_if_done", 64'(bus.if_done_o), 64'd1);
        check_val("lf_c10_if_data", 64'(bus.if_data_o), 64'h5A5A_0044);
      end
    end
    next_cyc;
    bus.d_req_i  = 1'b0;
    bus.if_req_i = 1'b0;
    mid;
    check_val("lf_c11_d_done",  64'(bus.d_done_o),  64'd0);
    check_val("lf_c11_if_done", 64'(bus.if_done_o), 64'd0);
    check_val("lf_n_grants", 64'(grants.size()), 64'd2);
    if (grants.size() == 2) begin
      check_val("lf_grant0", 64'(grants[0]), 64'h100);
      check_val("lf_grant1", 64'(grants[1]), 64'h44);
    end

    // Store, ack delay 2
    next_cyc;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 32'h0000_0008;
    bus.d_wdata_i = 32'hDEAD_BEEF;
    ack_delay     = 2;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) next_cyc;
      mid;
      if (c >= 1 && c <= 3) begin
        check_val($sformatf("st_c%0d_we", c),    64'(bus.mem_we_o),    64'd1);
        check_val($sformatf("st_c%0d_wdata", c), 64'(bus.mem_wdata_o), 64'hDEAD_BEEF);
        check_val($sformatf("st_c%0d_addr", c),  64'(bus.mem_addr_o),  64'h8);
      end
      if (c == 4) begin
        check_val("st_c4_d_done",  64'(bus.d_done_o),  64'd1);
        check_val("st_c4_stall",   64'(bus.stall_o),   64'd0);
        check_val("st_c4_d_rdata", 64'(bus.d_rdata_o), 64'h5A5A_0100);
      end
    end
    next_cyc;
    bus.d_req_i = 1'b0;
    bus.d_we_i  = 1'b0;

    // Timeout: no ack for 19 busy cycles, then a late ack
    next_cyc;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0080;
    never_ack     = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      next_cyc; mid;
      if (c == 15) check_val("to_c15_timeout", 64'(bus.timeout_o), 64'd0);
      if (c == 16) check_val("to_c16_timeout", 64'(bus.timeout_o), 64'd1);
      if (c == 19) begin
        check_val("to_c19_stall",   64'(bus.stall_o),   64'd1);
        check_val("to_c19_mem_req", 64'(bus.mem_req_o), 64'd1);
        never_ack = 1'b0;
      end
    end
    next_cyc;
    next_cyc; mid;
    check_val("to_c21_if_done", 64'(bus.if_done_o), 64'd1);
    check_val("to_c21_if_data", 64'(bus.if_data_o), 64'h5A5A_0080);
    check_val("to_c21_timeout", 64'(bus.timeout_o), 64'd1);
    check_val("to_c21_stall",   64'(bus.stall_o),   64'd0);
    next_cyc;
    bus.if_req_i = 1'b0;

    // Async reset while the fetch half of a load+fetch pair is outstanding
    next_cyc;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = 32'h0000_0200;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0084;
    ack_delay     = 0;
    next_cyc; mid;
    never_ack = 1'b1;
    next_cyc;
    next_cyc; mid;
    check_val("ar_pre_mem_req", 64'(bus.mem_req_o),  64'd1);
    check_val("ar_pre_d_done",  64'(bus.d_done_o),   64'd1);
    check_val("ar_pre_addr",    64'(bus.mem_addr_o), 64'h84);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_val("ar_mem_req", 64'(bus.mem_req_o), 64'd0);
    check_val("ar_stall",   64'(bus.stall_o),   64'd0);
    check_val("ar_d_done",  64'(bus.d_done_o),  64'd0);
    check_val("ar_if_done", 64'(bus.if_done_o), 64'd0);
    check_val("ar_timeout", 64'(bus.timeout_o), 64'd0);
    check_val("ar_d_rdata", 64'(bus.d_rdata_o), 64'd0);
    bus.d_req_i  = 1'b0;
    bus.if_req_i = 1'b0;
    never_ack    = 1'b0;
    mid;
    rst_n_i = 1'b1;

    // After reset the arbiter is idle and grants the next request at once
    next_cyc;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_00C0;
    next_cyc; mid;
    check_val("pr_c1_mem_req", 64'(bus.mem_req_o),  64'd1);
    check_val("pr_c1_addr",    64'(bus.mem_addr_o), 64'hC0);
    next_cyc; mid;
    check_val("pr_c2_if_done", 64'(bus.if_done_o), 64'd1);
    check_val("pr_c2_if_data", 64'(bus.if_data_o), 64'h5A5A_00C0);
    next_cyc;
    bus.if_req_i = 1'b0;
    next_cyc;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
